// File: rtl/full_mat_ctrl.sv
// rtl/full_mat_ctrl.sv - host register file and run sequencer for the full_mat datapath
//
// Ports:
//   clk, rst           clock and asynchronous active-low reset
//   chipselect, write, read, address[5:0], writedata[31:0]
//                      slave bus; strobes qualified by chipselect
//   readdata[31:0]     registered read data, valid the cycle after a read strobe
//   irq                level interrupt, registered done & irq_en
//   fm_en, fm_rst      full_mat enable and active-high reset
//   fm_dh_param        6 joints x 4 params (theta, a, d, alpha) shadow registers
//   fm_full_matrix     4x4 row-major result from full_mat, latched on capture
module full_mat_ctrl #(
    parameter int CLR_CYCLES = 6,
    parameter int RUN_CYCLES = 90,
    parameter int DATA_W     = 27
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic                          read,
    input  logic [5:0]                    address,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic                          irq,
    output logic                          fm_en,
    output logic                          fm_rst,
    output logic [5:0][3:0][DATA_W-1:0]   fm_dh_param,
    input  logic [3:0][3:0][DATA_W-1:0]   fm_full_matrix
);

    localparam int CNT_MAX = (RUN_CYCLES > CLR_CYCLES) ? RUN_CYCLES : CLR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [5:0][3:0][DATA_W-1:0]   param_q, param_d;
    logic [3:0][3:0][DATA_W-1:0]   result_q, result_d;
    logic                          irq_en_q, irq_en_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;
    logic                          irq_q, irq_d;
    logic [31:0]                   readdata_q, readdata_d;

    logic        busy;
    logic        wr_en, rd_en;
    logic        param_hit, ctrl_hit, status_hit, result_hit;
    logic        start_req, abort_req, done_clr, err_clr, err_set;
    logic [31:0] rd_word;

    // Upper write-data bits beyond the parameter width carry no meaning.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:DATA_W];

    function automatic logic [31:0] sext(input logic [DATA_W-1:0] v);
        return {{(32 - DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // Bus decode
    always_comb begin
        wr_en      = chipselect & write;
        rd_en      = chipselect & read;
        param_hit  = (address < 6'd24);
        ctrl_hit   = (address == 6'h18);
        status_hit = (address == 6'h19);
        result_hit = (address[5:4] == 2'b10);
        // Abort dominates start when both bits arrive in one write.
        start_req  = wr_en & ctrl_hit & writedata[0] & ~writedata[1];
        abort_req  = wr_en & ctrl_hit & writedata[1];
        done_clr   = wr_en & status_hit & writedata[1];
        err_clr    = wr_en & status_hit & writedata[2];
    end

    // State register and all other flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            param_q    <= '0;
            result_q   <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            param_q    <= param_d;
            result_q   <= result_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = CNT_W'(CLR_CYCLES - 1);
                end else if (state_q == S_DONE && done_clr) begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_W'(RUN_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs; fm_rst comes straight from the state register so
    // reset forces it high without waiting for a clock.
    always_comb begin
        busy   = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_CAPTURE);
        fm_en  = (state_q == S_RUN);
        fm_rst = (state_q != S_RUN);
    end

    // Register file, status bits and read path
    always_comb begin
        param_d    = param_q;
        result_d   = result_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        err_d      = err_q;
        readdata_d = readdata_q;
        rd_word    = '0;

        err_set = busy & ((wr_en & param_hit) | start_req);

        if (wr_en && param_hit && !busy)
            param_d[address[4:2]][address[1:0]] = writedata[DATA_W-1:0];

        if (wr_en && ctrl_hit)
            irq_en_d = writedata[2];

        if (state_q == S_CAPTURE)
            result_d = fm_full_matrix;

        // Capture setting done takes priority over a coincident W1C.
        if (state_q == S_CAPTURE)
            done_d = 1'b1;
        else if ((start_req && !busy) || done_clr)
            done_d = 1'b0;

        if (err_set)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;

        irq_d = done_q & irq_en_q;

        if (param_hit)
            rd_word = sext(param_q[address[4:2]][address[1:0]]);
        else if (ctrl_hit)
            rd_word = {29'b0, irq_en_q, 2'b0};
        else if (status_hit)
            rd_word = {29'b0, err_q, done_q, busy};
        else if (result_hit)
            rd_word = sext(result_q[address[3:2]][address[1:0]]);

        if (rd_en)
            readdata_d = rd_word;
    end

    assign readdata    = readdata_q;
    assign irq         = irq_q;
    assign fm_dh_param = param_q;

endmodule

// File: tb/tb_full_mat_ctrl.sv
// tb/tb_full_mat_ctrl.sv - directed self-checking bench for full_mat_ctrl
module tb_full_mat_ctrl;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     chipselect;
    logic                     write;
    logic                     read;
    logic [5:0]               address;
    logic [31:0]              writedata;
    logic [31:0]              readdata;
    logic                     irq;
    logic                     fm_en;
    logic                     fm_rst;
    logic [5:0][3:0][26:0]    fm_dh_param;
    logic [3:0][3:0][26:0]    fm_full_matrix;

    int checks   = 0;
    int failures = 0;

    full_mat_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .chipselect     (chipselect),
        .write          (write),
        .read           (read),
        .address        (address),
        .writedata      (writedata),
        .readdata       (readdata),
        .irq            (irq),
        .fm_en          (fm_en),
        .fm_rst         (fm_rst),
        .fm_dh_param    (fm_dh_param),
        .fm_full_matrix (fm_full_matrix)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    function automatic logic [26:0] mat_val(input int seed, input int i);
        logic [25:0] low;
        low = 26'(seed * 4099 + i * 131 + 7);
        return {(i % 2 == 1), low};
    endfunction

    function automatic logic [31:0] sext27(input logic [26:0] v);
        return {{5{v[26]}}, v};
    endfunction

    task automatic set_matrix(input int seed);
        for (int i = 0; i < 16; i++)
            fm_full_matrix[i / 4][i % 4] = mat_val(seed, i);
    endtask

    task automatic check_results(input string tag, input int seed);
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            bus_read(6'h20 + 6'(i), d);
            check($sformatf("%s_res%0d", tag, i), d, sext27(mat_val(seed, i)));
        end
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (!irq && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_irq_wait"}, 32'(irq), 32'd1);
    endtask

    task automatic wait_fm_en(input string tag);
        int n;
        n = 0;
        while (!fm_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_fm_en_wait"}, 32'(fm_en), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int clr_cnt, run_cnt, irq_at, rst_bad, n;
        logic en_seen, param_stable;

        vecs[0]  = '{1'b1, 6'h00, 32'h0000_0001};
        vecs[1]  = '{1'b0, 6'h00, 32'h0000_0001};
        vecs[2]  = '{1'b1, 6'h01, 32'h0400_0000};
        vecs[3]  = '{1'b0, 6'h01, 32'hFC00_0000};
        vecs[4]  = '{1'b1, 6'h17, 32'h07FF_FFFF};
        vecs[5]  = '{1'b0, 6'h17, 32'hFFFF_FFFF};
        vecs[6]  = '{1'b1, 6'h17, 32'hF3FF_FFFF};
        vecs[7]  = '{1'b0, 6'h17, 32'h03FF_FFFF};
        vecs[8]  = '{1'b1, 6'h0A, 32'h02AA_AAAA};
        vecs[9]  = '{1'b0, 6'h0A, 32'h02AA_AAAA};
        vecs[10] = '{1'b1, 6'h18, 32'h0000_0004};
        vecs[11] = '{1'b0, 6'h18, 32'h0000_0004};
        vecs[12] = '{1'b1, 6'h18, 32'h0000_0000};
        vecs[13] = '{1'b0, 6'h18, 32'h0000_0000};
        vecs[14] = '{1'b0, 6'h19, 32'h0000_0000};
        vecs[15] = '{1'b1, 6'h20, 32'h0000_0123};
        vecs[16] = '{1'b0, 6'h20, 32'h0000_0000};
        vecs[17] = '{1'b1, 6'h30, 32'h0000_0055};
        vecs[18] = '{1'b0, 6'h30, 32'h0000_0000};
        vecs[19] = '{1'b0, 6'h1A, 32'h0000_0000};
        vecs[20] = '{1'b0, 6'h2F, 32'h0000_0000};

        rst = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; fm_full_matrix = '0;
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_fm_en", 32'(fm_en), 32'h0);
        check("rst_fm_rst", 32'(fm_rst), 32'h1);
        rst = 1'b1;

        // Register access table
        for (int i = 0; i < 21; i++) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, d);
                check($sformatf("vec%0d_addr%02h", i, vecs[i].addr), d, vecs[i].data);
            end
        end
        check("dh_j5_alpha", 32'(fm_dh_param[5][3]), 32'h03FF_FFFF);
        check("dh_j2_d", 32'(fm_dh_param[2][2]), 32'h02AA_AAAA);
        bus_read(6'h0A, d);
        repeat (2) @(negedge clk);
        check("readdata_hold", readdata, 32'h02AA_AAAA);

        // Full run with zero params, timing measured from the start edge
        for (int a = 0; a < 24; a++) bus_write(6'(a), 32'h0);
        set_matrix(1);
        bus_write(6'h18, 32'h5);
        clr_cnt = 0; run_cnt = 0; irq_at = -1; rst_bad = 0;
        en_seen = 1'b0; param_stable = 1'b1;
        for (int j = 0; j < 300 && irq_at < 0; j++) begin
            if (j > 0) @(negedge clk);
            if (fm_en) begin
                run_cnt++;
                en_seen = 1'b1;
                if (fm_rst) rst_bad++;
            end else if (!en_seen && fm_rst) begin
                clr_cnt++;
            end
            if (fm_dh_param !== '0) param_stable = 1'b0;
            if (irq) irq_at = j;
        end
        check("run1_clear_cycles", 32'(clr_cnt), 32'd6);
        check("run1_run_cycles", 32'(run_cnt), 32'd90);
        check("run1_rst_during_en", 32'(rst_bad), 32'd0);
        check("run1_irq_latency", 32'(irq_at), 32'd98);
        check("run1_param_stable", 32'(param_stable), 32'd1);
        bus_read(6'h19, d);
        check("run1_status_done", d, 32'h2);
        check_results("run1", 1);

        // Busy-time writes: param drop, start ignored, err W1C
        set_matrix(2);
        bus_write(6'h18, 32'h5);
        repeat (20) @(negedge clk);
        check("run2_in_run", 32'(fm_en), 32'd1);
        bus_write(6'h05, 32'h0000_0123);
        bus_read(6'h19, d);
        check("run2_status_err", d, 32'h5);
        bus_read(6'h05, d);
        check("run2_param_kept", d, 32'h0);
        check("run2_dh_stable", 32'(fm_dh_param == '0), 32'd1);
        bus_write(6'h19, 32'h4);
        bus_read(6'h19, d);
        check("run2_err_cleared", d, 32'h1);
        bus_write(6'h18, 32'h5);
        bus_read(6'h19, d);
        check("run2_start_busy_err", d, 32'h5);
        bus_write(6'h19, 32'h4);
        wait_irq("run2");
        bus_read(6'h19, d);
        check("run2_status_done", d, 32'h2);
        check_results("run2", 2);

        // Abort mid-run keeps old results; fresh start completes
        set_matrix(3);
        bus_write(6'h18, 32'h5);
        wait_fm_en("run3");
        repeat (39) @(negedge clk);
        bus_write(6'h18, 32'h6);
        check("abort_fm_en", 32'(fm_en), 32'd0);
        check("abort_fm_rst", 32'(fm_rst), 32'd1);
        bus_read(6'h19, d);
        check("abort_status", d, 32'h0);
        check("abort_irq", 32'(irq), 32'd0);
        check_results("abort", 2);
        bus_write(6'h18, 32'h5);
        wait_irq("run4");
        check_results("run4", 3);

        // Start from DONE, irq_en toggling, W1C done back to IDLE
        bus_write(6'h18, 32'h1);
        bus_read(6'h19, d);
        check("restart_status", d, 32'h1);
        n = 0;
        d = 32'h0;
        while (d[1] !== 1'b1 && n < 100) begin
            bus_read(6'h19, d);
            n++;
        end
        check("run5_status_done", d, 32'h2);
        check("run5_irq_masked", 32'(irq), 32'd0);
        bus_write(6'h18, 32'h4);
        check("irq_en_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_en_rise", 32'(irq), 32'd1);
        bus_write(6'h19, 32'h2);
        check("done_clr_irq_lag", 32'(irq), 32'd1);
        @(negedge clk);
        check("done_clr_irq_drop", 32'(irq), 32'd0);
        bus_read(6'h19, d);
        check("idle_status", d, 32'h0);
        bus_write(6'h18, 32'h3);
        repeat (3) @(negedge clk);
        check("start_abort_fm_en", 32'(fm_en), 32'd0);
        check("start_abort_fm_rst", 32'(fm_rst), 32'd1);
        bus_read(6'h19, d);
        check("start_abort_status", d, 32'h0);

        // Reset mid-run
        bus_write(6'h02, 32'h0000_0077);
        bus_write(6'h18, 32'h5);
        wait_fm_en("run6");
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_fm_en", 32'(fm_en), 32'd0);
        check("midrst_fm_rst", 32'(fm_rst), 32'd1);
        check("midrst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("midrst_dh_zero", 32'(fm_dh_param == '0), 32'd1);
        for (int a = 0; a < 48; a++) begin
            bus_read(6'(a), d);
            check($sformatf("post_rst_addr%02h", a), d, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
